// File: rtl/memory_stage.sv
// memory_stage: pipeline memory stage with a fixed-latency data memory.
//
// Non-memory ops go straight through the output register in one cycle.
// A memory op is captured into holding registers. Stall then stays high for
// MEM_LAT cycles and the output register carries bubbles during that time.
// The memory access and the result load happen together on the DONE edge.
//
// Ports:
//   clk            clock, rising edge
//   rst            asynchronous active-low reset
//   MEM_signals    {memRead, memWrite, memAddress, memData}
//   WB_signals     {regWrite, WBsel[1:0]}
//   Rsrc, Rdst     register operands (address / write-data sources)
//   ALU_Out        execute result (address source, passed through)
//   Imm            immediate word (passed through)
//   WA_in          write-back register address
//   stall          hold request to upstream stages (combinational)
//   *_out, RD_out  registered stage outputs
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | accepting ops; non-memory ops pass through in one cycle
// BUSY  | memory access in flight, cnt counts down to DONE
// DONE  | perform write / read, emit held result, return to IDLE

module memory_stage #(
  parameter int MEM_LAT = 2,
  parameter int AW      = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  MEM_signals,
  input  logic [2:0]  WB_signals,
  input  logic [15:0] Rsrc,
  input  logic [15:0] Rdst,
  input  logic [15:0] ALU_Out,
  input  logic [15:0] Imm,
  input  logic [2:0]  WA_in,
  output logic        stall,
  output logic [2:0]  WB_signals_out,
  output logic [15:0] RD_out,
  output logic [15:0] ALU_Out_out,
  output logic [15:0] Imm_out,
  output logic [2:0]  WA_out
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state, state_nxt;
  logic [3:0] cnt;

  logic mem_read, mem_write, mem_addr_sel, mem_data_sel;
  assign {mem_read, mem_write, mem_addr_sel, mem_data_sel} = MEM_signals;

  logic          mem_op;
  logic [AW-1:0] addr;
  logic [15:0]   wdata;

  assign mem_op = mem_read | mem_write;
  // Only the low AW bits take part, so addresses wrap modulo 2^AW.
  assign addr   = mem_addr_sel ? ALU_Out[AW-1:0] : Rsrc[AW-1:0];
  assign wdata  = mem_data_sel ? Rsrc : Rdst;

  logic [AW-1:0] hold_addr;
  logic [15:0]   hold_wdata;
  logic          hold_write;
  logic [2:0]    hold_wb;
  logic [15:0]   hold_alu;
  logic [15:0]   hold_imm;
  logic [2:0]    hold_wa;

  logic [15:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op) begin
          stall     = 1'b1;
          state_nxt = (MEM_LAT > 1) ? BUSY : DONE;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (cnt == 4'd1) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // While reset is held the state is IDLE but the inputs may still show an
    // op; stall must read 0 then.
    if (!rst) stall = 1'b0;
  end

  // Memory keeps its contents through reset. It is written on the DONE edge only.
  always_ff @(posedge clk) begin
    if (state == DONE && hold_write) mem[hold_addr] <= hold_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt            <= '0;
      hold_addr      <= '0;
      hold_wdata     <= '0;
      hold_write     <= 1'b0;
      hold_wb        <= '0;
      hold_alu       <= '0;
      hold_imm       <= '0;
      hold_wa        <= '0;
      WB_signals_out <= '0;
      RD_out         <= '0;
      ALU_Out_out    <= '0;
      Imm_out        <= '0;
      WA_out         <= '0;
    end else begin
      // Bubble unless overridden below.
      WB_signals_out <= '0;
      RD_out         <= '0;
      ALU_Out_out    <= '0;
      Imm_out        <= '0;
      WA_out         <= '0;
      case (state)
        IDLE: begin
          if (mem_op) begin
            cnt        <= 4'(MEM_LAT - 1);
            hold_addr  <= addr;
            hold_wdata <= wdata;
            // Read+write together counts as a write.
            hold_write <= mem_write;
            hold_wb    <= WB_signals;
            hold_alu   <= ALU_Out;
            hold_imm   <= Imm;
            hold_wa    <= WA_in;
          end else begin
            WB_signals_out <= WB_signals;
            ALU_Out_out    <= ALU_Out;
            Imm_out        <= Imm;
            WA_out         <= WA_in;
          end
        end
        BUSY: cnt <= cnt - 4'd1;
        DONE: begin
          cnt            <= '0;
          WB_signals_out <= hold_wb;
          ALU_Out_out    <= hold_alu;
          Imm_out        <= hold_imm;
          WA_out         <= hold_wa;
          RD_out         <= hold_write ? 16'h0000 : mem[hold_addr];
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;

  localparam int AW = 10;

  typedef struct packed {
    logic [2:0]  wb;
    logic [15:0] rd;
    logic [15:0] alu;
    logic [15:0] imm;
    logic [2:0]  wa;
  } res_t;

  logic        clk;
  logic        rst;
  logic [3:0]  MEM_signals;
  logic [2:0]  WB_signals;
  logic [15:0] Rsrc, Rdst, ALU_Out, Imm;
  logic [2:0]  WA_in;

  logic        stall_a, stall_b;
  logic [2:0]  wb_a, wb_b, wa_a, wa_b;
  logic [15:0] rd_a, rd_b, alu_a, alu_b, imm_a, imm_b;

  int n_checks = 0;
  int n_errors = 0;

  res_t exp_q[$];
  logic [15:0] mdl_a [int];
  logic [15:0] mdl_b [int];

  memory_stage #(.MEM_LAT(2), .AW(AW)) dut_a (
    .clk(clk), .rst(rst), .MEM_signals(MEM_signals), .WB_signals(WB_signals),
    .Rsrc(Rsrc), .Rdst(Rdst), .ALU_Out(ALU_Out), .Imm(Imm), .WA_in(WA_in),
    .stall(stall_a), .WB_signals_out(wb_a), .RD_out(rd_a),
    .ALU_Out_out(alu_a), .Imm_out(imm_a), .WA_out(wa_a)
  );

  memory_stage #(.MEM_LAT(1), .AW(AW)) dut_b (
    .clk(clk), .rst(rst), .MEM_signals(MEM_signals), .WB_signals(WB_signals),
    .Rsrc(Rsrc), .Rdst(Rdst), .ALU_Out(ALU_Out), .Imm(Imm), .WA_in(WA_in),
    .stall(stall_b), .WB_signals_out(wb_b), .RD_out(rd_b),
    .ALU_Out_out(alu_b), .Imm_out(imm_b), .WA_out(wa_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic get_out(input int lat, output res_t o, output logic st);
    if (lat == 1) begin
      o  = '{wb: wb_b, rd: rd_b, alu: alu_b, imm: imm_b, wa: wa_b};
      st = stall_b;
    end else begin
      o  = '{wb: wb_a, rd: rd_a, alu: alu_a, imm: imm_a, wa: wa_a};
      st = stall_a;
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the result edge.
  task automatic run_op(input int lat, input logic [3:0] ms, input logic [2:0] wb,
                        input logic [15:0] rs, input logic [15:0] rdst,
                        input logic [15:0] alu, input logic [15:0] imm,
                        input logic [2:0] wa);
    res_t        e, o;
    logic        st;
    logic [15:0] a, wd;
    int          key;
    logic        is_mem;
    MEM_signals = ms; WB_signals = wb; Rsrc = rs; Rdst = rdst;
    ALU_Out = alu; Imm = imm; WA_in = wa;
    is_mem = ms[3] | ms[2];
    a   = ms[1] ? alu : rs;
    key = int'(a[AW-1:0]);
    wd  = ms[0] ? rs : rdst;
    e   = '{wb: wb, rd: 16'h0000, alu: alu, imm: imm, wa: wa};
    if (ms[2]) begin
      if (lat == 1) mdl_b[key] = wd; else mdl_a[key] = wd;
    end else if (ms[3]) begin
      e.rd = (lat == 1) ? mdl_b[key] : mdl_a[key];
    end
    exp_q.push_back(e);
    #1;
    get_out(lat, o, st);
    chk("stall_on_present", 64'(st), 64'(is_mem));
    if (is_mem) begin
      for (int c = 1; c <= lat; c++) begin
        @(posedge clk); @(negedge clk);
        get_out(lat, o, st);
        chk("bubble", 64'(o), 64'(0));
        chk("stall_in_op", 64'(st), 64'(c < lat));
      end
    end
    @(posedge clk); @(negedge clk);
    get_out(lat, o, st);
    e = exp_q.pop_front();
    chk("wb_out",  64'(o.wb),  64'(e.wb));
    chk("rd_out",  64'(o.rd),  64'(e.rd));
    chk("alu_out", 64'(o.alu), 64'(e.alu));
    chk("imm_out", 64'(o.imm), 64'(e.imm));
    chk("wa_out",  64'(o.wa),  64'(e.wa));
  endtask

  initial begin
    res_t o;
    logic st;
    rst = 1'b0;
    MEM_signals = '0; WB_signals = '0; Rsrc = '0; Rdst = '0;
    ALU_Out = '0; Imm = '0; WA_in = '0;
    #2;
    get_out(2, o, st);
    chk("reset_out_a", 64'(o), 64'(0));
    chk("reset_stall_a", 64'(st), 64'(0));
    get_out(1, o, st);
    chk("reset_out_b", 64'(o), 64'(0));
    @(negedge clk);
    rst = 1'b1;

    // Pass-through ops.
    run_op(2, 4'b0000, 3'b100, 16'h0000, 16'h0000, 16'h1234, 16'h0000, 3'd5);
    run_op(2, 4'b0000, 3'b011, 16'h1111, 16'h2222, 16'hABCD, 16'h7777, 3'd2);
    // Write then read back, back to back.
    run_op(2, 4'b0111, 3'b000, 16'h00AA, 16'h0000, 16'h0010, 16'h0000, 3'd0);
    run_op(2, 4'b1000, 3'b101, 16'h0010, 16'h0000, 16'h9999, 16'h4242, 3'd3);
    // Address wrap.
    run_op(2, 4'b0110, 3'b000, 16'h0000, 16'hBEEF, 16'h0403, 16'h0000, 3'd0);
    run_op(2, 4'b1000, 3'b110, 16'h0003, 16'h0000, 16'h0001, 16'h0002, 3'd4);
    // Read and write together behave as a write.
    run_op(2, 4'b1100, 3'b110, 16'h0007, 16'h5555, 16'h0000, 16'h0000, 3'd1);
    run_op(2, 4'b1000, 3'b100, 16'h0007, 16'h0000, 16'h0000, 16'h0000, 3'd6);
    run_op(2, 4'b0000, 3'b001, 16'h0000, 16'h0000, 16'hCAFE, 16'hF00D, 3'd7);
    run_op(2, 4'b0110, 3'b000, 16'h0000, 16'h0001, 16'h0009, 16'h0000, 3'd0);

    // Abort a write to address 9 in BUSY.
    MEM_signals = 4'b0110; ALU_Out = 16'h0009; Rdst = 16'hFFFF;
    WB_signals = 3'b111; Imm = 16'h1357; WA_in = 3'd3;
    #1;
    get_out(2, o, st);
    chk("abort_stall_idle", 64'(st), 64'(1));
    @(posedge clk); @(negedge clk);
    get_out(2, o, st);
    chk("abort_stall_busy", 64'(st), 64'(1));
    rst = 1'b0;
    #1;
    get_out(2, o, st);
    chk("abort_stall_drop", 64'(st), 64'(0));
    chk("abort_out_zero", 64'(o), 64'(0));
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst = 1'b1;
    run_op(2, 4'b1010, 3'b100, 16'h0000, 16'h0000, 16'h0009, 16'h0000, 3'd2);
    run_op(2, 4'b1000, 3'b100, 16'h0010, 16'h0000, 16'h0000, 16'h0000, 3'd1);

    // Single-cycle latency instance.
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_op(1, 4'b0110, 3'b000, 16'h0000, 16'h1111, 16'h0020, 16'h0000, 3'd0);
    run_op(1, 4'b0110, 3'b000, 16'h0000, 16'h2222, 16'h0021, 16'h0000, 3'd0);
    run_op(1, 4'b1000, 3'b101, 16'h0020, 16'h0000, 16'h0000, 16'h0000, 3'd2);
    run_op(1, 4'b1000, 3'b101, 16'h0021, 16'h0000, 16'h0000, 16'h0000, 3'd3);

    MEM_signals = '0;
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
